ram_stream_reader: RTL
======================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 256, giving the memory word and stream width.
REQ-002 SHALL have parameter ADDR_W, default 4, giving the memory address width (16 words).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin a burst read.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: first word address, sampled with start.
REQ-007 SHALL have port count, input, ADDR_W+1 bits: number of words in the burst (0..16), sampled with start.
REQ-008 SHALL have port mem_addr, output, ADDR_W bits: read address to the synchronous RAM.
REQ-009 SHALL have port mem_we, output, 1 bit: RAM write enable, tied to 0.
REQ-010 SHALL have port mem_q, input, DATA_W bits: RAM read data, valid one clock after mem_addr is sampled.
REQ-011 SHALL have port out_data, output, DATA_W bits: streamed word.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-014 SHALL have port busy, output, 1 bit: a burst is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, PRESENT and FINISH.
REQ-017 In IDLE with start=1 and count>0: latch ptr=base_addr and remaining=count, then go to ISSUE.
REQ-018 In IDLE with start=1 and count=0: go to FINISH with no RAM access.
REQ-019 In ISSUE: mem_addr=ptr; go to WAIT.
REQ-020 In WAIT: capture mem_q into out_data and set out_valid=1; go to PRESENT.
REQ-021 In PRESENT: hold out_data and out_valid stable until out_valid&&out_ready.
REQ-022 On the PRESENT handshake: clear out_valid, set ptr=ptr+1 mod 2^ADDR_W (15 wraps to 0), and decrement remaining; go to ISSUE if remaining was >1, otherwise to FINISH.
REQ-023 In FINISH: assert done for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Latency: start at edge N gives out_valid high from cycle N+3; maximum throughput is one word per 3 cycles.
REQ-026 start while busy=1 SHALL be ignored and SHALL NOT alter ptr or remaining.
REQ-027 mem_addr SHALL hold ptr in all states; mem_we SHALL be constantly 0.
REQ-028 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-029 RST=1 at a clock edge SHALL force IDLE with out_valid=0, done=0, busy=0, out_data=0, ptr=0, remaining=0 and checksum=0.
REQ-030 RST asserted mid-burst SHALL abort the burst with no done pulse, and any pending word SHALL be dropped.

Configuration
REQ-031 With macro READ_CHECKSUM_EN defined, the block SHALL add output chk, DATA_W bits: XOR of all words accepted in the burst, cleared on start and valid while done=1.
REQ-032 Without READ_CHECKSUM_EN, the chk port and its logic SHALL be absent.

Structure
REQ-033 The state encoding and the DATA_W/ADDR_W defaults SHALL live in the shared package nn_mem_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the RAM is external.

Verification
REQ-035 Bench: RAM preloaded mem[k]=k; start, base=2, count=3, out_ready=1 -> words 2,3,4 in order; done one cycle after the third handshake.
REQ-036 Bench: base=14, count=4 -> words 14,15,0,1 (address wrap-around).
REQ-037 Bench: out_ready=0 for 5 cycles during PRESENT -> out_data and out_valid held stable, no extra RAM address change.
REQ-038 Bench: count=0 -> done pulse 2 cycles after start, out_valid never asserted.
REQ-039 Bench: RST pulsed during the second word -> out_valid=0 and busy=0 next cycle, no done; a new start then behaves normally.
REQ-040 Bench with READ_CHECKSUM_EN: words 1,2,3 -> chk=0 while done=1.

Source files
------------

// File: rtl/nn_mem_pkg.sv
// Shared definitions for the nn memory blocks: reader FSM encoding and default
// memory geometry.
package nn_mem_pkg;

  localparam int unsigned NN_DATA_W = 256;
  localparam int unsigned NN_ADDR_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_FINISH  = 3'd4
  } rd_state_t;

endpackage : nn_mem_pkg

// File: rtl/ram_stream_reader.sv
// Burst reader: fetches count words from an external synchronous RAM starting at
// base_addr and streams them out with valid/ready. Optional macro READ_CHECKSUM_EN adds chk.
module ram_stream_reader
  import nn_mem_pkg::*;
#(
  parameter int unsigned DATA_W = NN_DATA_W,
  parameter int unsigned ADDR_W = NN_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef READ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chk
`endif
);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            ptr_d   = base_addr;
            rem_d   = count;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        data_d  = mem_q;
        valid_d = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          state_d = (rem_q > (ADDR_W+1)'(1)) ? S_ISSUE : S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = ptr_q;
  assign mem_we    = 1'b0;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);

`ifdef READ_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;

  // Cleared by any start accepted in IDLE, including count=0, so chk reads 0 then.
  always_comb begin
    chk_d = chk_q;
    if (state_q == S_IDLE && start) begin
      chk_d = '0;
    end else if (state_q == S_PRESENT && valid_q && out_ready) begin
      chk_d = chk_q ^ data_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign chk = chk_q;
`endif

endmodule : ram_stream_reader
